// File: rtl/sample_decim_pkg.sv
// Shared constants for the sample_decim decimator: mode encodings,
// default widths and the shift-port width.
package sample_decim_pkg;

    localparam logic MODE_PICK = 1'b0;
    localparam logic MODE_AVG  = 1'b1;

    localparam int DEF_DATA_W  = 10;
    localparam int DEF_RATIO_W = 8;
    localparam int SHIFT_W     = 5;

endpackage

// File: rtl/sample_decim_ctr.sv
// Frame counter for sample_decim: latches the ratio at frame start (0 maps
// to 1) and flags the first and last accepted sample of each frame.
module sample_decim_ctr
    import sample_decim_pkg::*;
#(
    parameter int RATIO_W = DEF_RATIO_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic               i_accept,
    input  logic [RATIO_W-1:0] i_ratio,
    output logic               o_first_acc,
    output logic               o_last_acc
);

    logic [RATIO_W-1:0] r_cnt;
    logic [RATIO_W-1:0] r_ratio_q;
    logic [RATIO_W-1:0] w_ratio_map;
    logic [RATIO_W-1:0] w_ratio_eff;

    // The first accept of a frame must already use the incoming ratio,
    // otherwise ratio 1 frames would need an extra accept to complete.
    always_comb begin
        w_ratio_map = (i_ratio == '0) ? RATIO_W'(1) : i_ratio;
        w_ratio_eff = (r_cnt == '0) ? w_ratio_map : r_ratio_q;
    end

    assign o_first_acc = i_accept && (r_cnt == '0);
    assign o_last_acc  = i_accept && (r_cnt == w_ratio_eff - RATIO_W'(1));

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt     <= '0;
            r_ratio_q <= '0;
        end else if (!i_en) begin
            r_cnt <= '0;
        end else if (i_accept) begin
            if (o_first_acc) begin
                r_ratio_q <= w_ratio_map;
            end
            r_cnt <= o_last_acc ? '0 : r_cnt + RATIO_W'(1);
        end
    end

endmodule

// File: rtl/sample_decim.sv
// Runtime-configurable pick/average decimator for the ADC sample path.
// Optional macro SAMPLE_DECIM_SAT_EN saturates average results instead of wrapping.
module sample_decim
    import sample_decim_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int RATIO_W = DEF_RATIO_W
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               en,
    input  logic [RATIO_W-1:0] ratio,
    input  logic               mode,
    input  logic [SHIFT_W-1:0] shift,
    input  logic               din_valid,
    input  logic [DATA_W-1:0]  din,
    output logic               dout_valid,
    output logic [DATA_W-1:0]  dout,
    output logic               sat_flag
);

    localparam int ACC_W = DATA_W + RATIO_W;

    logic               w_accept;
    logic               w_first;
    logic               w_last;
    logic               w_mode_eff;
    logic [SHIFT_W-1:0] w_shift_eff;
    logic [ACC_W-1:0]   w_sum;
    logic [DATA_W-1:0]  w_avg;
    logic               w_sat;
`ifdef SAMPLE_DECIM_SAT_EN
    logic [ACC_W-1:0]   w_shifted;
`endif

    logic               r_mode_q;
    logic [SHIFT_W-1:0] r_shift_q;
    logic [ACC_W-1:0]   r_acc;
    logic               r_dout_valid;
    logic [DATA_W-1:0]  r_dout;
    logic               r_sat;

    assign w_accept = en && din_valid;

    sample_decim_ctr #(
        .RATIO_W (RATIO_W)
    ) u_ctr (
        .clk         (clk),
        .rst         (rst),
        .i_en        (en),
        .i_accept    (w_accept),
        .i_ratio     (ratio),
        .o_first_acc (w_first),
        .o_last_acc  (w_last)
    );

    // NOTE: every signal driven here gets a value on every path, so no
    // latches are inferred.
    always_comb begin
        w_mode_eff  = w_first ? mode  : r_mode_q;
        w_shift_eff = w_first ? shift : r_shift_q;
        w_sum       = (w_first ? '0 : r_acc) + ACC_W'(din);
`ifdef SAMPLE_DECIM_SAT_EN
        w_shifted = w_sum >> w_shift_eff;
        w_sat     = |w_shifted[ACC_W-1:DATA_W];
        w_avg     = w_sat ? '1 : w_shifted[DATA_W-1:0];
`else
        w_sat = 1'b0;
        w_avg = DATA_W'(w_sum >> w_shift_eff);
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode_q  <= MODE_PICK;
            r_shift_q <= '0;
            r_acc     <= '0;
        end else if (!en) begin
            r_acc <= '0;
        end else if (w_accept) begin
            if (w_first) begin
                r_mode_q  <= mode;
                r_shift_q <= shift;
            end
            if (w_mode_eff == MODE_AVG) begin
                r_acc <= w_sum;
            end
        end
    end

    // Data and flag only change on a completed frame and hold otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_dout_valid <= 1'b0;
            r_dout       <= '0;
            r_sat        <= 1'b0;
        end else begin
            r_dout_valid <= w_last;
            if (w_last) begin
                r_dout <= (w_mode_eff == MODE_AVG) ? w_avg : din;
                r_sat  <= (w_mode_eff == MODE_AVG) && w_sat;
            end
        end
    end

    assign dout_valid = r_dout_valid;
    assign dout       = r_dout;
    assign sat_flag   = r_sat;

endmodule

// File: tb/tb_sample_decim.sv
// Self-checking bench for sample_decim: table of per-cycle vectors whose
// expected strobes go through a scoreboard queue, plus hand-written reset cases.
module tb_sample_decim;
    import sample_decim_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic [7:0]  ratio;
    logic        mode;
    logic [4:0]  shift;
    logic        din_valid;
    logic [9:0]  din;
    logic        dout_valid;
    logic [9:0]  dout;
    logic        sat_flag;

    sample_decim dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .ratio      (ratio),
        .mode       (mode),
        .shift      (shift),
        .din_valid  (din_valid),
        .din        (din),
        .dout_valid (dout_valid),
        .dout       (dout),
        .sat_flag   (sat_flag)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       dv;
        logic [9:0] din;
        logic [7:0] ratio;
        logic       mode;
        logic [4:0] shift;
        logic       exp_v;
        logic [9:0] exp_dout;
        logic       exp_sat;
    } vec_t;

    typedef struct {
        int         due;
        logic [9:0] dout;
        logic       sat;
    } exp_t;

    vec_t       vecs[$];
    exp_t       sb[$];
    int         cyc = 0;
    int         n_checks = 0;
    int         n_pass = 0;
    logic [9:0] held_dout = '0;
    logic       held_sat = 1'b0;
    logic [9:0] sat_dout;
    logic       sat_f;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s (cycle %0d): got %0d, expected %0d", name, cyc, act, exp);
    endtask

    task automatic add(input logic e, input logic dv, input int d, input int r, input logic m,
                       input int s, input logic xv, input int xd, input logic xs);
        vec_t v;
        v.en = e; v.dv = dv; v.din = 10'(d); v.ratio = 8'(r); v.mode = m; v.shift = 5'(s);
        v.exp_v = xv; v.exp_dout = 10'(xd); v.exp_sat = xs;
        vecs.push_back(v);
    endtask

    // Compares outputs against the scoreboard head and the held values.
    task automatic check_outputs();
        logic exp_v;
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        check("dout_valid", 32'(dout_valid), 32'(exp_v));
        if (exp_v) begin
            held_dout = sb[0].dout;
            held_sat  = sb[0].sat;
            void'(sb.pop_front());
        end
        check("dout", 32'(dout), 32'(held_dout));
        check("sat_flag", 32'(sat_flag), 32'(held_sat));
    endtask

    task automatic step(input vec_t v);
        en = v.en; din_valid = v.dv; din = v.din;
        ratio = v.ratio; mode = v.mode; shift = v.shift;
        if (v.exp_v) sb.push_back('{due: cyc + 1, dout: v.exp_dout, sat: v.exp_sat});
        @(posedge clk);
        cyc++;
        #1;
        check_outputs();
    endtask

    task automatic run_pick4(input int d, input logic xv);
        vec_t v;
        v.en = 1'b1; v.dv = 1'b1; v.din = 10'(d); v.ratio = 8'd4; v.mode = MODE_PICK;
        v.shift = '0; v.exp_v = xv; v.exp_dout = 10'(d); v.exp_sat = 1'b0;
        step(v);
    endtask

    initial begin
`ifdef SAMPLE_DECIM_SAT_EN
        sat_dout = 10'd1023; sat_f = 1'b1;
`else
        sat_dout = 10'd1020; sat_f = 1'b0;
`endif
        // Pick, ratio 11, continuous ramp: strobes carry 10, 21, 32
        for (int i = 0; i < 33; i++) add(1, 1, i, 11, MODE_PICK, 0, (i % 11) == 10, i, 0);
        // Average, ratio 4, shift 2: (100+200+300+400)>>2 = 250
        add(1, 1, 100, 4, MODE_AVG, 2, 0, 0, 0);
        add(1, 1, 200, 4, MODE_AVG, 2, 0, 0, 0);
        add(1, 1, 300, 4, MODE_AVG, 2, 0, 0, 0);
        add(1, 1, 400, 4, MODE_AVG, 2, 1, 250, 0);
        // Ratio 0 acts as 1: a strobe per sample
        add(1, 1, 5, 0, MODE_PICK, 0, 1, 5, 0);
        add(1, 1, 6, 0, MODE_PICK, 0, 1, 6, 0);
        add(1, 1, 7, 0, MODE_PICK, 0, 1, 7, 0);
        // Ratio changed 4 -> 8 after two accepts: applies from next frame
        add(1, 1, 40, 4, MODE_PICK, 0, 0, 0, 0);
        add(1, 1, 41, 4, MODE_PICK, 0, 0, 0, 0);
        for (int i = 42; i < 52; i++) add(1, 1, i, 8, MODE_PICK, 0, i == 43 || i == 51, i, 0);
        // Ratio 3 with valid every other cycle
        add(1, 1, 60, 3, MODE_PICK, 0, 0, 0, 0);
        add(1, 0, 99, 3, MODE_PICK, 0, 0, 0, 0);
        add(1, 1, 61, 3, MODE_PICK, 0, 0, 0, 0);
        add(1, 0, 99, 3, MODE_PICK, 0, 0, 0, 0);
        add(1, 1, 62, 3, MODE_PICK, 0, 1, 62, 0);
        // en low after two accepts discards the partial frame
        add(1, 1, 70, 4, MODE_PICK, 0, 0, 0, 0);
        add(1, 1, 71, 4, MODE_PICK, 0, 0, 0, 0);
        add(0, 1, 98, 4, MODE_PICK, 0, 0, 0, 0);
        add(1, 1, 72, 4, MODE_PICK, 0, 0, 0, 0);
        add(1, 1, 73, 4, MODE_PICK, 0, 0, 0, 0);
        add(1, 1, 74, 4, MODE_PICK, 0, 0, 0, 0);
        add(1, 1, 75, 4, MODE_PICK, 0, 1, 75, 0);
        // Average with en flush: partial sum 1000 dropped, (4+8+12+16)>>2 = 10
        add(1, 1, 500, 4, MODE_AVG, 2, 0, 0, 0);
        add(1, 1, 500, 4, MODE_AVG, 2, 0, 0, 0);
        add(0, 0, 0, 4, MODE_AVG, 2, 0, 0, 0);
        add(1, 1, 4, 4, MODE_AVG, 2, 0, 0, 0);
        add(1, 1, 8, 4, MODE_AVG, 2, 0, 0, 0);
        add(1, 1, 12, 4, MODE_AVG, 2, 0, 0, 0);
        add(1, 1, 16, 4, MODE_AVG, 2, 1, 10, 0);
        // Full-scale average: saturate or wrap depending on build
        for (int i = 0; i < 4; i++) add(1, 1, 1023, 4, MODE_AVG, 0, i == 3, sat_dout, sat_f);
        // Fresh accumulation after a full-scale frame: (10+20)>>1 = 15
        add(1, 1, 10, 2, MODE_AVG, 1, 0, 0, 0);
        add(1, 1, 20, 2, MODE_AVG, 1, 1, 15, 0);
        // Mode/ratio change mid-frame ignored: 3+5 averaged with shift 0
        add(1, 1, 3, 2, MODE_AVG, 0, 0, 0, 0);
        add(1, 1, 5, 9, MODE_PICK, 5, 1, 8, 0);

        rst = 1'b1; en = 1'b0; din_valid = 1'b0; din = '0;
        ratio = '0; mode = MODE_PICK; shift = '0;
        #13;
        check("reset dout_valid", 32'(dout_valid), 32'd0);
        check("reset dout", 32'(dout), 32'd0);
        check("reset sat_flag", 32'(sat_flag), 32'd0);
        rst = 1'b0;
        @(posedge clk); cyc++; #1;

        foreach (vecs[i]) step(vecs[i]);

        // Reset mid-frame: no strobe, dout back to 0, then a fresh frame of 4
        run_pick4(80, 1'b0);
        run_pick4(81, 1'b0);
        rst = 1'b1;
        #2;
        check("mid-reset dout", 32'(dout), 32'd0);
        check("mid-reset dout_valid", 32'(dout_valid), 32'd0);
        held_dout = '0;
        held_sat  = 1'b0;
        rst = 1'b0;
        run_pick4(82, 1'b0);
        run_pick4(83, 1'b0);
        run_pick4(84, 1'b0);
        run_pick4(85, 1'b1);

        // Idle cycles: no spurious strobe, outputs held
        en = 1'b1; din_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); cyc++; #1;
            check_outputs();
        end
        check("scoreboard drained", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/sample_decim.md
Name: sample_decim

Overview:
- Parametrised, runtime-configurable decimator for the ADC sample path. It replaces the fixed divide-by-11 sample picker.
- Accepts a valid-qualified sample stream and emits one sample per frame of R accepted inputs, where R is selectable at run time.
- Two modes:
  - Pick: keep the last sample of the frame.
  - Average: accumulate the frame, then right-shift the sum.
- Sits between the ADC capture logic and the downstream DSP/FIFO. The output is a one-cycle valid strobe plus held data.

Parameters:
- DATA_W, 10, sample width in bits. Samples are unsigned, offset binary.
- RATIO_W, 8, width of the ratio port. Maximum decimation is 2^RATIO_W-1.
- ACC_W, DATA_W+RATIO_W, accumulator width. Derived; do not override.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- en  in  1  block enable; low flushes the current frame
- ratio  in  RATIO_W  decimation ratio R; 0 is treated as 1
- mode  in  1  0 = pick, 1 = average
- shift  in  5  average mode only: right shift applied to the frame sum
- din_valid  in  1  input sample qualifier
- din  in  DATA_W  input sample
- dout_valid  out  1  one-cycle strobe, one per completed frame
- dout  out  DATA_W  decimated sample; held between strobes
- sat_flag  out  1  set with dout_valid when the average result was saturated; tied 0 without the macro

Behaviour:
- Reset: async on rst high. dout_valid=0, dout=0, sat_flag=0; internal cnt=0, acc=0, latched config=0.
- Accept: a sample is accepted when en=1 and din_valid=1 on a rising clk.
- Frame start: on the accept with cnt==0, latch ratio_q (0 mapped to 1), mode_q and shift_q.
  - Config changes mid-frame take effect only at the next frame start.
- Counter: cnt increments on each accept.
  - On the accept with cnt==ratio_q-1 (the last accept), cnt returns to 0.
  - No accept means no change to cnt or acc.
- Accumulator (mode_q=1):
  - First accept of a frame: acc=din.
  - Subsequent accepts: acc=acc+din.
  - Zero-extend din to ACC_W. ACC_W guarantees no accumulator overflow.
- Output on the last accept, registered, one-cycle latency (dout_valid high the cycle after the last sample's edge):
  - Pick: dout = din of the last accepted sample.
  - Average: result = (acc+din)>>shift_q, truncated to the low DATA_W bits (wrap).
  - dout_valid=1 for exactly one cycle unless the next frame also completes. With ratio 1 and continuous valid, dout_valid stays high continuously.
- Between strobes: dout_valid=0, and dout and sat_flag hold their last value.
- en low: cnt and acc clear at the next edge, the partial frame is discarded, and dout_valid=0. dout holds. Config is re-latched on the next accept after en returns high.
- Gaps in din_valid are allowed anywhere in a frame. The frame ends only after ratio_q accepts.
- Reset mid-frame: the partial frame is discarded, no output is generated, and the next frame starts fresh.
- Pick mode does not update acc.

Optional Feature:
- Macro: SAMPLE_DECIM_SAT_EN.
- Defined: in average mode, if (acc+din)>>shift_q exceeds 2^DATA_W-1, dout = all ones and sat_flag=1 with the strobe; otherwise sat_flag=0.
- Undefined: truncation wraps as described above, and sat_flag is constant 0.
- Pick mode is unaffected in both cases.

Decomposition:
- Package sample_decim_pkg holds:
  - mode constants MODE_PICK=1'b0 and MODE_AVG=1'b1
  - default DATA_W and RATIO_W
  - the shift port width (5)
- One sub-module, sample_decim_ctr: frame counter with ratio latch and 0→1 mapping. Outputs first_acc and last_acc flags.
- Accumulator, mode mux and output registers stay in the top level.

Test Plan:
- Pick mode, ratio=11, din_valid=1 continuous, din ramp 0,1,2,... → dout_valid pulses every 11 cycles; dout=10, 21, 32; each pulse one cycle after the sample's edge.
- Average mode, ratio=4, shift=2, din=100,200,300,400 → single strobe with dout=250.
- ratio=0, pick, din=5,6,7 continuous → dout_valid high for 3 cycles; dout=5,6,7 with one-cycle latency.
- Pick mode, ratio=4 then changed to 8 after 2 accepts → first strobe after the 4th accept, next strobe after 8 further accepts. Separately: ratio=3 with din_valid every other cycle → strobe only after the 3rd valid sample.
- Pick mode, ratio=4: rst or en=0 pulsed after 2 accepts → no strobe; dout holds (0 after rst). The next strobe comes after 4 fresh accepts.
- Average mode, ratio=4, shift=0, din=1023 ×4:
  - With SAMPLE_DECIM_SAT_EN: dout=1023, sat_flag=1.
  - Without: dout=1020, sat_flag=0.
